// File: rtl/decode_stage_pkg.sv
// Shared RISC-V definitions: ALU operation codes, opcode/funct fields,
// immediate formats and the decoded-instruction record.
package decode_stage_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_S    = 2'd2,
    IMM_B    = 2'd3
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        branch_ne;
    logic [31:0] rs2_data;
    logic [31:0] branch_target;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/decode_stage_alu_decoder.sv
// Combinational RV32 subset decoder: instruction word + operands -> dec_t.
// Zero latency, no state, no flow control.
module alu_decoder
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       legal;
  logic [3:0] alu;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       branch;
  imm_fmt_e   fmt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

  always_comb begin
    legal     = 1'b0;
    alu       = ALU_ADD;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    fmt       = IMM_NONE;
    case (opcode)
      OP_REG: begin
        reg_write = 1'b1;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          case (funct3)
            F3_ADD_SUB: alu = ALU_ADD;
            F3_AND:     alu = ALU_AND;
            F3_OR:      alu = ALU_OR;
            F3_XOR:     alu = ALU_XOR;
            default:    legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          legal = 1'b1;
          alu   = ALU_SUB;
        end
      end
      OP_IMM: begin
        reg_write = 1'b1;
        fmt       = IMM_I;
        legal     = 1'b1;
        case (funct3)
          F3_ADD_SUB: alu = ALU_ADD;
          F3_AND:     alu = ALU_AND;
          F3_OR:      alu = ALU_OR;
          F3_XOR:     alu = ALU_XOR;
          default:    legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        legal     = (funct3 == F3_WORD);
        fmt       = IMM_I;
        mem_read  = 1'b1;
        reg_write = 1'b1;
      end
      OP_STORE: begin
        legal     = (funct3 == F3_WORD);
        fmt       = IMM_S;
        mem_write = 1'b1;
      end
      OP_BRANCH: begin
        legal  = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
        fmt    = IMM_B;
        alu    = ALU_SUB;
        branch = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Unknown encodings must not disturb architectural state downstream.
    if (!legal) begin
      alu       = ALU_ADD;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
    end
  end

  always_comb begin
    dec               = '0;
    dec.a             = rs1_data;
    dec.rs2_data      = rs2_data;
    dec.branch_target = pc + imm_b(instr);
    dec.alu_ctrl      = alu;
    dec.rd            = rd;
    dec.reg_write     = reg_write && (rd != 5'd0);
    dec.mem_read      = mem_read;
    dec.mem_write     = mem_write;
    dec.branch        = branch;
    dec.branch_ne     = branch && funct3[0];
    dec.illegal       = !legal;
    case (fmt)
      IMM_I:   dec.b = imm_i(instr);
      IMM_S:   dec.b = imm_s(instr);
      default: dec.b = rs2_data;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one-entry output register, valid/ready both sides, 1-cycle latency.
// Holds payload while out_ready=0; flush empties the stage and blocks capture that cycle.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int ILLEGAL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  input  logic                     flush,
  output logic [4:0]               rs1_addr,
  output logic [4:0]               rs2_addr,
  input  logic [31:0]              rs1_data,
  input  logic [31:0]              rs2_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_a,
  output logic [31:0]              out_b,
  output logic [3:0]               out_alu_ctrl,
  output logic [4:0]               out_rd,
  output logic                     out_reg_write,
  output logic                     out_mem_read,
  output logic                     out_mem_write,
  output logic                     out_branch,
  output logic                     out_branch_ne,
  output logic [31:0]              out_rs2_data,
  output logic [31:0]              out_branch_target,
  output logic                     out_illegal,
  output logic [ILLEGAL_CNT_W-1:0] illegal_count
);

  dec_t                     dec;
  dec_t                     dec_d;
  dec_t                     dec_q;
  logic                     valid_d;
  logic                     valid_q;
  logic [ILLEGAL_CNT_W-1:0] cnt_d;
  logic [ILLEGAL_CNT_W-1:0] cnt_q;
  logic                     accept;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  alu_decoder u_alu_decoder (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dec      (dec)
  );

  // Flush is folded into in_ready, so an accept can never coincide with a flush.
  always_comb begin
    in_ready = (!valid_q || out_ready) && !flush;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    valid_d = valid_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      dec_d   = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (accept && dec.illegal && (cnt_q != {ILLEGAL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid         = valid_q;
  assign out_a             = dec_q.a;
  assign out_b             = dec_q.b;
  assign out_alu_ctrl      = dec_q.alu_ctrl;
  assign out_rd            = dec_q.rd;
  assign out_reg_write     = dec_q.reg_write;
  assign out_mem_read      = dec_q.mem_read;
  assign out_mem_write     = dec_q.mem_write;
  assign out_branch        = dec_q.branch;
  assign out_branch_ne     = dec_q.branch_ne;
  assign out_rs2_data      = dec_q.rs2_data;
  assign out_branch_target = dec_q.branch_target;
  assign out_illegal       = dec_q.illegal;
  assign illegal_count     = cnt_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL take parameter ILLEGAL_CNT_W, default 16, as the width of the saturating illegal-instruction counter.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: clk (input, 1) is the rising-edge clock and rst (input, 1) is the reset.
REQ-003 The block SHALL have these ports:
- in_valid, input, 1: fetch offers an instruction.
- in_ready, output, 1: the stage accepts an instruction.
- in_instr, input, 32: the instruction word.
- in_pc, input, 32: the instruction address.
- flush, input, 1: discard the stage contents.
- rs1_addr and rs2_addr, output, 5 each: register-file read addresses.
- rs1_data and rs2_data, input, 32 each: register-file read data.
- out_valid, output, 1, and out_ready, input, 1: the execute-side handshake.
- out_a and out_b, output, 32 each: ALU operands.
- out_alu_ctrl, output, 4: ALU operation code.
- out_rd, output, 5: destination register.
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_branch_ne, output, 1 each: control flags.
- out_rs2_data, output, 32: store data.
- out_branch_target, output, 32: branch target address.
- out_illegal, output, 1: illegal-instruction flag.
- illegal_count, output, ILLEGAL_CNT_W: count of accepted illegal instructions.

Function
REQ-004 rs1_addr SHALL equal in_instr[19:15] and rs2_addr SHALL equal in_instr[24:20], both combinationally.
REQ-005 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-006 An instruction SHALL be accepted on a rising edge when in_valid && in_ready, and its decoded result SHALL appear on the outputs with out_valid=1 in the next cycle (latency 1).
REQ-007 When out_valid=1 and out_ready=0, all out_* payload signals SHALL hold their values unchanged.
REQ-008 When out_valid && out_ready is true and no new instruction is accepted, out_valid SHALL go to 0 on the next edge.
REQ-009 A simultaneous output transfer and input accept SHALL replace the held payload with no bubble.
REQ-010 Flush SHALL take priority over every other event: out_valid=0 on the next edge, and no instruction is captured in the flush cycle.
REQ-011 The decode table SHALL be, with every operation code taken from the shared ALU encodings:
- opcode 0110011, funct7 0000000: funct3 000 ADD, 111 AND, 110 OR, 100 XOR.
- opcode 0110011, funct7 0100000, funct3 000: SUB.
- opcode 0010011: funct3 000 ADDI, 111 ANDI, 110 ORI, 100 XORI; out_b is the sign-extended I-immediate.
- opcode 0000011, funct3 010 (LW): ADD, out_b is the I-immediate, mem_read=1, reg_write=1.
- opcode 0100011, funct3 010 (SW): ADD, out_b is the S-immediate, mem_write=1, reg_write=0.
- opcode 1100011, funct3 000 (BEQ) or 001 (BNE): SUB, out_b=rs2_data, branch=1, branch_ne=funct3[0].
REQ-012 out_a SHALL always equal rs1_data, and out_rs2_data SHALL always equal rs2_data.
REQ-013 out_branch_target SHALL equal in_pc plus the sign-extended B-immediate, computed modulo 2^32 (wraps, no overflow flag), and SHALL be computed for every instruction.
REQ-014 out_reg_write SHALL be forced to 0 when rd=0.
REQ-015 Any encoding not listed in REQ-011 SHALL produce:
- out_illegal=1;
- reg_write, mem_read, mem_write and branch all 0;
- out_alu_ctrl equal to the ALU ADD code.
REQ-016 illegal_count SHALL increment by 1 on each accepted illegal instruction and SHALL saturate at all-ones.
REQ-017 An illegal instruction accepted in a flush cycle SHALL NOT be counted.

Reset
REQ-018 While rst=1, all of the following SHALL be 0 asynchronously and stay 0 until the first edge after release:
- out_valid;
- every out_* payload register;
- illegal_count.
REQ-019 A reset asserted mid-operation SHALL discard the held instruction, and no output transfer SHALL be reported for it.

Structure
REQ-020 The ALU operation encodings SHALL come only from the shared RISC-V defines header, with no local redefinition.
REQ-021 The opcode, funct3 and funct7 constants and the immediate-format enumeration SHALL be added to that same shared header.
REQ-022 The purely combinational instruction decode SHALL be one sub-module, alu_decoder; decode_stage SHALL hold only the pipeline register, the handshake logic and the counter.

Verification
REQ-023 ADD: in_instr=0x002081B3, rs1_data=5, rs2_data=7 -> next cycle out_valid=1, out_a=5, out_b=7, ADD code, out_rd=3, out_reg_write=1.
REQ-024 ADDI: in_instr=0xFFF00093 -> out_b=0xFFFFFFFF, out_rd=1, out_reg_write=1.
REQ-025 BEQ: in_instr=0x00208463, in_pc=0x100 -> SUB code, out_branch=1, out_branch_ne=0, out_branch_target=0x108.
REQ-026 Backpressure: out_ready=0 for 3 cycles while full with in_valid=1 -> payload stable, in_ready=0; then out_ready=1 -> exactly one transfer, next instruction follows with no loss or duplicate.
REQ-027 Flush while full with in_valid=1 -> out_valid=0 next cycle and the offered instruction is not captured.
REQ-028 Illegal: in_instr=0xFFFFFFFF accepted 3 times -> out_illegal=1, out_reg_write=0, illegal_count=3; with illegal_count preset to 0xFFFF by repeated stimulus, one more -> stays 0xFFFF.
